// File: rtl/dpram_req_scheduler_if.sv
// Client request/response channel of dpram_req_scheduler: valid/ready request with
// read/write, address and write data, and a valid/ready response carrying data and error.
interface dpram_req_scheduler_if #(
    parameter int AW = 8,
    parameter int DW = 8
) ();
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_data;
    logic          rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/dpram_req_scheduler.sv
// Two-client request scheduler in front of a dual-port RAM with collision resolution and
// occupancy tracking. Define DPRAM_SCHED_RR_EN for round-robin collision arbitration.
//
// state | meaning
// IDLE  | ready for a request
// ISSUE | driving the RAM port, retried while losing a collision
// CAPT  | RAM read data arriving, captured at the end of this cycle
// RESP  | response presented until consumed
module dpram_req_scheduler #(
    parameter int DEPTH = 8,
    parameter int AW    = 8,
    parameter int DW    = 8,
    parameter int CW    = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    dpram_req_scheduler_if.slave  a,
    dpram_req_scheduler_if.slave  b,
    output logic                  ram_we_a,
    output logic [AW-1:0]         ram_addr_a,
    output logic [DW-1:0]         ram_din_a,
    input  logic [DW-1:0]         ram_dout_a,
    output logic                  ram_we_b,
    output logic [AW-1:0]         ram_addr_b,
    output logic [DW-1:0]         ram_din_b,
    input  logic [DW-1:0]         ram_dout_b,
    output logic [CW-1:0]         occupancy,
    output logic                  full
);
    localparam int              IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]     DEPTH_W = (AW+1)'(DEPTH);
    localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, ISSUE, CAPT, RESP} state_t;

    state_t           state [2];
    logic [1:0]       we_q;
    logic [1:0]       req_ready_q;
    logic [1:0]       rsp_valid_q;
    logic [1:0]       rsp_err_q;
    logic [AW-1:0]    addr_q [2];
    logic [DW-1:0]    wdata_q [2];
    logic [DW-1:0]    rsp_data_q [2];
    logic [DEPTH-1:0] bitmap;

    logic [1:0]       req_valid;
    logic [1:0]       req_we;
    logic [1:0]       rsp_ready;
    logic [AW-1:0]    req_addr [2];
    logic [DW-1:0]    req_wdata [2];
    logic [DW-1:0]    ram_dout [2];

    logic [1:0]       grant;
    logic [1:0]       ram_we;
    logic [AW-1:0]    ram_addr [2];
    logic [DW-1:0]    ram_din [2];
    logic             collide;

`ifdef DPRAM_SCHED_RR_EN
    logic             last_win_b;
`endif

    assign req_valid    = {b.req_valid, a.req_valid};
    assign req_we       = {b.req_we, a.req_we};
    assign rsp_ready    = {b.rsp_ready, a.rsp_ready};
    assign req_addr[0]  = a.req_addr;
    assign req_addr[1]  = b.req_addr;
    assign req_wdata[0] = a.req_wdata;
    assign req_wdata[1] = b.req_wdata;
    assign ram_dout[0]  = ram_dout_a;
    assign ram_dout[1]  = ram_dout_b;

    assign a.req_ready = req_ready_q[0];
    assign a.rsp_valid = rsp_valid_q[0];
    assign a.rsp_data  = rsp_data_q[0];
    assign a.rsp_err   = rsp_err_q[0];
    assign b.req_ready = req_ready_q[1];
    assign b.rsp_valid = rsp_valid_q[1];
    assign b.rsp_data  = rsp_data_q[1];
    assign b.rsp_err   = rsp_err_q[1];

    assign ram_we_a   = ram_we[0];
    assign ram_addr_a = ram_addr[0];
    assign ram_din_a  = ram_din[0];
    assign ram_we_b   = ram_we[1];
    assign ram_addr_b = ram_addr[1];
    assign ram_din_b  = ram_din[1];

    // Two reads of the same word never collide; only a write makes ordering matter.
    always_comb begin
        collide = (state[0] == ISSUE) && (state[1] == ISSUE) &&
                  (addr_q[0] == addr_q[1]) && (we_q[0] || we_q[1]);
`ifdef DPRAM_SCHED_RR_EN
        grant[0] = !collide || last_win_b;
        grant[1] = !collide || !last_win_b;
`else
        grant[0] = 1'b1;
        grant[1] = !collide;
`endif
    end

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            ram_we[p]   = (state[p] == ISSUE) && we_q[p] && grant[p];
            ram_addr[p] = (state[p] == ISSUE) ? addr_q[p] : '0;
            ram_din[p]  = (state[p] == ISSUE) ? wdata_q[p] : '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            we_q        <= '0;
            req_ready_q <= '0;
            rsp_valid_q <= '0;
            rsp_err_q   <= '0;
            bitmap      <= '0;
            for (int p = 0; p < 2; p++) begin
                state[p]      <= IDLE;
                addr_q[p]     <= '0;
                wdata_q[p]    <= '0;
                rsp_data_q[p] <= '0;
            end
`ifdef DPRAM_SCHED_RR_EN
            last_win_b <= 1'b1;
`endif
        end else begin
`ifdef DPRAM_SCHED_RR_EN
            if (collide)
                last_win_b <= !last_win_b;
`endif
            for (int p = 0; p < 2; p++) begin
                case (state[p])
                    IDLE: begin
                        if (req_valid[p] && req_ready_q[p]) begin
                            we_q[p]        <= req_we[p];
                            addr_q[p]      <= req_addr[p];
                            wdata_q[p]     <= req_wdata[p];
                            req_ready_q[p] <= 1'b0;
                            if ({1'b0, req_addr[p]} >= DEPTH_W) begin
                                state[p]       <= RESP;
                                rsp_valid_q[p] <= 1'b1;
                                rsp_err_q[p]   <= 1'b1;
                                rsp_data_q[p]  <= '0;
                            end else begin
                                state[p] <= ISSUE;
                            end
                        end else begin
                            req_ready_q[p] <= 1'b1;
                        end
                    end
                    ISSUE: begin
                        if (grant[p]) begin
                            if (we_q[p]) begin
                                bitmap[addr_q[p][IW-1:0]] <= 1'b1;
                                state[p]       <= RESP;
                                rsp_valid_q[p] <= 1'b1;
                                rsp_err_q[p]   <= 1'b0;
                                rsp_data_q[p]  <= '0;
                            end else begin
                                state[p] <= CAPT;
                            end
                        end
                    end
                    CAPT: begin
                        state[p]       <= RESP;
                        rsp_valid_q[p] <= 1'b1;
                        rsp_data_q[p]  <= ram_dout[p];
                        rsp_err_q[p]   <= !bitmap[addr_q[p][IW-1:0]];
                    end
                    RESP: begin
                        if (rsp_ready[p]) begin
                            state[p]       <= IDLE;
                            req_ready_q[p] <= 1'b1;
                            rsp_valid_q[p] <= 1'b0;
                            rsp_err_q[p]   <= 1'b0;
                            rsp_data_q[p]  <= '0;
                        end
                    end
                    default: state[p] <= IDLE;
                endcase
            end
        end
    end

    always_comb begin
        occupancy = '0;
        for (int i = 0; i < DEPTH; i++)
            occupancy = occupancy + CW'(bitmap[i]);
    end

    assign full = (occupancy == DEPTH_C);
endmodule
